// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned, start/busy/done handshake.
// Optional early termination when the remaining multiplier bits are uniform: BOOTH_EARLY_TERM_EN.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int SW = 2*WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH:0]     m_r;
  logic [WIDTH:0]     a_r;
  logic [WIDTH:0]     q_r;
  logic               q1_r;
  logic [CW-1:0]      cnt_r;

  logic [WIDTH:0]     acc_s;
  logic [SW-1:0]      step_s;
  logic [CW-1:0]      cnt_nxt_s;

  // Booth add/subtract selected by the current and previous multiplier bits.
  always_comb begin
    case ({q_r[0], q1_r})
      2'b10:   acc_s = a_r - m_r;
      2'b01:   acc_s = a_r + m_r;
      default: acc_s = a_r;
    endcase
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:0]        mask_s;
  logic                  term_s;
  logic signed [SW-1:0]  full_s;
  logic [SW-1:0]         jump_s;

  // Detect that every unprocessed multiplier bit matches q_1 and prepare the multi-bit shift.
  always_comb begin
    mask_s = ~({(WIDTH+1){1'b1}} << cnt_r);
    term_s = (((q_r ^ {(WIDTH+1){q1_r}}) & mask_s) == {(WIDTH+1){1'b0}});
    full_s = {a_r, q_r, q1_r};
    jump_s = full_s >>> cnt_r;
  end
`endif

  // Next {A,Q,q_1} and step count for one RUN cycle; the shifted-out q_1 is dropped.
  always_comb begin
    step_s    = {acc_s[WIDTH], acc_s, q_r};
    cnt_nxt_s = cnt_r - CW'(1);
`ifdef BOOTH_EARLY_TERM_EN
    if (term_s) begin
      step_s    = jump_s;
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      step_s    = {acc_s[WIDTH], acc_s, q_r};
      cnt_nxt_s = cnt_r - CW'(1);
    end
`endif
  end

  // Control FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      m_r     <= {(WIDTH+1){1'b0}};
      a_r     <= {(WIDTH+1){1'b0}};
      q_r     <= {(WIDTH+1){1'b0}};
      q1_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r     <= {sgn & a[WIDTH-1], a};
            q_r     <= {sgn & b[WIDTH-1], b};
            a_r     <= {(WIDTH+1){1'b0}};
            q1_r    <= 1'b0;
            cnt_r   <= CW'(WIDTH + 1);
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          {a_r, q_r, q1_r} <= step_s;
          cnt_r            <= cnt_nxt_s;
          if (cnt_nxt_s == {CW{1'b0}}) begin
            // Upper bits of {A,Q} are redundant extension; the low 2*WIDTH are exact.
            product <= step_s[2*WIDTH:1];
            done    <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corners plus a random sweep against a plain-arithmetic model.
module tb_booth_mult_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sgn = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_prod = '0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint px;
    longint py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return 16'(px * py);
  endfunction

  // Edges from accept to the edge after which done is visible.
  function automatic int model_lat(input logic [W-1:0] y, input logic s);
    logic [W:0] e;
    int res;
    e = {s & y[W-1], y};
    res = W + 1;
`ifdef BOOTH_EARLY_TERM_EN
    for (int k = W; k >= 0; k--) begin
      logic prev;
      bit   same;
      prev = (k == 0) ? 1'b0 : e[k-1];
      same = 1'b1;
      for (int j = k; j <= W; j++) if (e[j] != prev) same = 1'b0;
      if (same) res = k + 1;
    end
`endif
    return res;
  endfunction

  // Every done cycle must be inside busy and carry the modelled product.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      chk("done_with_busy", {31'd0, busy}, 32'd1);
      chk("done_product", {16'd0, product}, {16'd0, exp_prod});
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input bit use_lit, input logic [2*W-1:0] lit, input int lit_lat,
                        input bit repulse);
    int n;
    int lat;
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    exp_prod = model_prod(x, y, s);
    lat = model_lat(y, s);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sgn = $urandom;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (repulse && n == 3) begin a = 8'd3; b = 8'd3; start = 1'b1; end
      if (repulse && n == 4) start = 1'b0;
    end
    chk("latency", n, lat);
    if (lit_lat >= 0) chk("latency_literal", n, lit_lat);
    if (use_lit) chk("product_literal", {16'd0, product}, {16'd0, lit});
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_falls", {31'd0, busy}, 32'd0);
    chk("product_held", {16'd0, product}, {16'd0, exp_prod});
  endtask

  initial begin
    int n;
    int dc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    rst = 1'b0;

`ifdef BOOTH_EARLY_TERM_EN
    run_op(8'd7, 8'hFD, 1'b1, 1'b1, 16'hFFEB, -1, 1'b0);
    run_op(8'h55, 8'h00, 1'b0, 1'b1, 16'h0000, 1, 1'b0);
    run_op(8'h05, 8'hFF, 1'b1, 1'b1, 16'hFFFB, 2, 1'b0);
`else
    run_op(8'd7, 8'hFD, 1'b1, 1'b1, 16'hFFEB, 9, 1'b0);
    run_op(8'h05, 8'hFF, 1'b1, 1'b1, 16'hFFFB, 9, 1'b0);
`endif
    run_op(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, -1, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, -1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, -1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001, -1, 1'b0);

    dc = done_cnt;
    run_op(8'd5, 8'd6, 1'b0, 1'b1, 16'd30, -1, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    chk("repulse_single_done", done_cnt - dc, 1);

    // Reset during the 4th RUN cycle of 9*9.
    @(negedge clk);
    a = 8'd9; b = 8'd9; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_product", {16'd0, product}, 32'd0);
`ifdef BOOTH_EARLY_TERM_EN
    run_op(8'd2, 8'd3, 1'b0, 1'b1, 16'd6, -1, 1'b0);
`else
    run_op(8'd2, 8'd3, 1'b0, 1'b1, 16'd6, 9, 1'b0);
`endif

    // Start held high: consecutive done pulses are latency+2 edges apart.
    @(negedge clk);
    a = 8'd2; b = 8'd3; sgn = 1'b0; start = 1'b1;
    exp_prod = model_prod(8'd2, 8'd3, 1'b0);
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("held_first_done", {31'd0, done}, 32'd1);
    n = 0;
    @(posedge clk); #1;
    n++;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("held_gap", n, model_lat(8'd3, 1'b0) + 2);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = $urandom;
      y = $urandom;
      if (i % 10 == 0) y = 8'h00;
      if (i % 10 == 1) y = 8'hFF;
      if (i % 10 == 2) x = 8'h80;
      run_op(x, y, 1'($urandom), 1'b0, 16'd0, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
